// File: rtl/mp_addsub_seq.sv
// Word-serial multi-precision add/subtract sequencer: one WIDTH-bit slice per clock, LSB first.
// Define MP_ADDSUB_SUB_EN to build the subtract path; otherwise the block is add-only and ignores i_sub.
`timescale 1ns/1ps
module mp_addsub_seq #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH*WORDS-1:0]   i_op1,
  input  logic [WIDTH*WORDS-1:0]   i_op2,
  input  logic                     i_carry_borrow,
  input  logic                     i_sub,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH*WORDS-1:0]   o_res,
  output logic                     o_carry_borrow
);

  localparam int TOTAL = WIDTH * WORDS;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [TOTAL-1:0]  op1_reg, op2_reg, res_reg;
  logic              cb_reg;
  logic              cout_reg;

  logic [WIDTH-1:0]  op1_w [WORDS];
  logic [WIDTH-1:0]  op2_w [WORDS];
  logic [WORDS-1:0]  wr_en;
  logic [WIDTH-1:0]  a_slice, b_slice, b_eff;
  logic              cin_eff, cb_out;
  logic [WIDTH:0]    sum;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_slice
      assign op1_w[gi] = op1_reg[gi*WIDTH +: WIDTH];
      assign op2_w[gi] = op2_reg[gi*WIDTH +: WIDTH];
      assign wr_en[gi] = (state_reg == RUN) && (cnt_reg == CW'(gi));
    end
  endgenerate

  assign a_slice = op1_w[cnt_reg];
  assign b_slice = op2_w[cnt_reg];

`ifdef MP_ADDSUB_SUB_EN
  logic sub_reg;
  // Subtract as op1 + ~op2 + ~b_in; the running flag is kept in borrow sense.
  assign b_eff   = sub_reg ? ~b_slice : b_slice;
  assign cin_eff = sub_reg ? ~cb_reg  : cb_reg;
  assign cb_out  = sub_reg ? ~sum[WIDTH] : sum[WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      sub_reg <= 1'b0;
    else if (state_reg == IDLE && i_valid)
      sub_reg <= i_sub;
  end
`else
  logic unused_sub;
  assign unused_sub = i_sub;
  assign b_eff      = b_slice;
  assign cin_eff    = cb_reg;
  assign cb_out     = sum[WIDTH];
`endif

  assign sum = {1'b0, a_slice} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_valid) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op1_reg   <= '0;
      op2_reg   <= '0;
      res_reg   <= '0;
      cb_reg    <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && i_valid) begin
        op1_reg <= i_op1;
        op2_reg <= i_op2;
        cb_reg  <= i_carry_borrow;
        cnt_reg <= '0;
      end
      if (state_reg == RUN) begin
        cb_reg  <= cb_out;
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == LAST)
          cout_reg <= cb_out;
      end
      for (int k = 0; k < WORDS; k++) begin
        if (wr_en[k])
          res_reg[k*WIDTH +: WIDTH] <= sum[WIDTH-1:0];
      end
    end
  end

  // Ready is masked while reset is held so the source cannot hand over work then.
  assign o_ready        = (state_reg == IDLE) && i_rst_n;
  assign o_valid        = (state_reg == DONE);
  assign o_res          = res_reg;
  assign o_carry_borrow = cout_reg;

endmodule
